// File: rtl/multiplier_taint_pkg.sv
// Shared definitions for the shift-add multiplier and its taint-tracking datapath.
// The control block imports this package too, so the encodings here are the
// contract between the two blocks.
package multiplier_taint_pkg;

    // Default operand width; the product is twice this wide.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Result-register operation selected for one cycle.
    typedef enum logic [1:0] {
        ResHold  = 2'd0,
        ResClear = 2'd1,
        ResLoad  = 2'd2,
        ResShift = 2'd3
    } res_op_e;

    // Priority resolve of the result strobes: clear > load (add) > shift.
    function automatic res_op_e res_op_sel(input logic clr, input logic ld, input logic shr);
        res_op_e op;
        if (clr) begin
            op = ResClear;
        end else if (ld) begin
            op = ResLoad;
        end else if (shr) begin
            op = ResShift;
        end else begin
            op = ResHold;
        end
        return op;
    endfunction

    // True when two or more result strobes are raised in the same cycle.
    function automatic logic res_conflict(input logic clr, input logic ld, input logic shr);
        return (clr & ld) | (clr & shr) | (ld & shr);
    endfunction

endpackage

// File: rtl/taint_word_reg.sv
// Word register with a single taint bit. Loads value and merged taint on
// load; a tainted strobe that is not asserted leaves the value alone but still
// taints the register, since the decision not to load depended on it.
module taint_word_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_t,
    input  logic [WIDTH-1:0] data,
    input  logic             data_t,
    output logic [WIDTH-1:0] value,
    output logic             value_t
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             value_t_q, value_t_d;

    // Next-state: load, or merge taint when the strobe itself is tainted.
    always_comb begin
        value_d   = value_q;
        value_t_d = value_t_q;
        if (load) begin
            value_d   = data;
            value_t_d = data_t | load_t;
        end else if (load_t) begin
            // The operation would have used data_t; a tainted strobe always taints.
            value_t_d = value_t_q | data_t | 1'b1;
        end
    end

    // State update with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= '0;
            value_t_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            value_t_q <= value_t_d;
        end
    end

    assign value   = value_q;
    assign value_t = value_t_q;

endmodule

// File: rtl/multiplier_datapath_taint_track_word.sv
// Datapath of the sequential shift-add multiplier with word-level taint.
// Executes the control block's strobes (load multiplicand/multiplier, clear,
// add, shift right) and returns the multiplier register for bit-serial
// decisions. Each register carries one conservative taint bit.
module multiplier_datapath_taint_track_word
    import multiplier_taint_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               multiplicand_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               multiplier_t,
    input  logic               mdld,
    input  logic               mdld_t,
    input  logic               mrld,
    input  logic               mrld_t,
    input  logic               rsclear,
    input  logic               rsclear_t,
    input  logic               rsload,
    input  logic               rsload_t,
    input  logic               rsshr,
    input  logic               rsshr_t,
    output logic [WIDTH-1:0]   multiplierReg,
    output logic               multiplierReg_t,
    output logic [2*WIDTH-1:0] product,
    output logic               product_t,
    output logic               ctrl_conflict
);

    logic [WIDTH-1:0] md_q;
    logic             md_t_q;
    logic [WIDTH-1:0] mr_q;
    logic             mr_t_q;

    // Result register carries one extra carry bit above the product.
    logic [2*WIDTH:0] res_q, res_d;
    logic             res_t_q, res_t_d;
    logic             conflict_q, conflict_d;

    res_op_e          res_op;
    logic [WIDTH:0]   sum;
    logic             strobe_t_any;

    taint_word_reg #(
        .WIDTH (WIDTH)
    ) u_md_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (mdld),
        .load_t  (mdld_t),
        .data    (multiplicand),
        .data_t  (multiplicand_t),
        .value   (md_q),
        .value_t (md_t_q)
    );

    taint_word_reg #(
        .WIDTH (WIDTH)
    ) u_mr_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (mrld),
        .load_t  (mrld_t),
        .data    (multiplier),
        .data_t  (multiplier_t),
        .value   (mr_q),
        .value_t (mr_t_q)
    );

    // The add uses the current (old) multiplicand even if mdld fires this cycle.
    assign sum = {1'b0, res_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};

    // Any tainted result strobe taints the result, asserted or not, and
    // whether or not its operation won the priority resolve.
    assign strobe_t_any = rsclear_t | rsload_t | rsshr_t;

    // Result-register next state and taint merge.
    always_comb begin
        res_op     = res_op_sel(rsclear, rsload, rsshr);
        res_d      = res_q;
        res_t_d    = res_t_q | strobe_t_any;
        conflict_d = conflict_q | res_conflict(rsclear, rsload, rsshr);
        unique case (res_op)
            ResClear: begin
                res_d   = '0;
                // Only place (besides rst) where taint can drop.
                res_t_d = strobe_t_any;
            end
            ResLoad: begin
                res_d   = {sum, res_q[WIDTH-1:0]};
                res_t_d = res_t_q | md_t_q | strobe_t_any;
            end
            ResShift: begin
                res_d = {1'b0, res_q[2*WIDTH:1]};
            end
            ResHold: begin
                res_d = res_q;
            end
        endcase
    end

    // Result, result taint and sticky conflict flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q      <= '0;
            res_t_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            res_q      <= res_d;
            res_t_q    <= res_t_d;
            conflict_q <= conflict_d;
        end
    end

    assign multiplierReg   = mr_q;
    assign multiplierReg_t = mr_t_q;
    assign product         = res_q[2*WIDTH-1:0];
    assign product_t       = res_t_q;
    assign ctrl_conflict   = conflict_q;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// Self-checking bench for multiplier_datapath_taint_track_word.
module tb_multiplier_datapath_taint_track_word;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   multiplicand = '0;
    logic           multiplicand_t = 1'b0;
    logic [W-1:0]   multiplier = '0;
    logic           multiplier_t = 1'b0;
    logic           mdld = 1'b0, mdld_t = 1'b0;
    logic           mrld = 1'b0, mrld_t = 1'b0;
    logic           rsclear = 1'b0, rsclear_t = 1'b0;
    logic           rsload = 1'b0, rsload_t = 1'b0;
    logic           rsshr = 1'b0, rsshr_t = 1'b0;
    logic [W-1:0]   multiplierReg;
    logic           multiplierReg_t;
    logic [2*W-1:0] product;
    logic           product_t;
    logic           ctrl_conflict;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state (plain integers).
    int m_md, m_mr, m_res;
    bit m_md_t, m_mr_t, m_res_t, m_conf;

    multiplier_datapath_taint_track_word #(
        .WIDTH (W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .multiplicand    (multiplicand),
        .multiplicand_t  (multiplicand_t),
        .multiplier      (multiplier),
        .multiplier_t    (multiplier_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
        .product         (product),
        .product_t       (product_t),
        .ctrl_conflict   (ctrl_conflict)
    );

    always #5 clk = ~clk;

    // Spec-level model of one clock edge, evaluated from the applied inputs.
    function automatic void model_step();
        int  old_md   = m_md;
        bit  old_md_t = m_md_t;
        int  hi;
        int  n;
        bit  any_t;
        if (rst) begin
            m_md = 0; m_md_t = 0; m_mr = 0; m_mr_t = 0;
            m_res = 0; m_res_t = 0; m_conf = 0;
            return;
        end
        if (mdld) begin
            m_md = int'(multiplicand); m_md_t = multiplicand_t | mdld_t;
        end else if (mdld_t) begin
            m_md_t = 1;
        end
        if (mrld) begin
            m_mr = int'(multiplier); m_mr_t = multiplier_t | mrld_t;
        end else if (mrld_t) begin
            m_mr_t = 1;
        end
        n = int'(rsclear) + int'(rsload) + int'(rsshr);
        if (n >= 2) m_conf = 1;
        any_t = rsclear_t | rsload_t | rsshr_t;
        if (rsclear) begin
            m_res = 0;
            m_res_t = any_t;
        end else if (rsload) begin
            hi = ((m_res / 16) % 16) + old_md;
            m_res = hi * 16 + (m_res % 16);
            m_res_t = m_res_t | old_md_t | any_t;
        end else if (rsshr) begin
            m_res = m_res / 2;
            m_res_t = m_res_t | any_t;
        end else begin
            m_res_t = m_res_t | any_t;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0;
        rsclear = 0; rsclear_t = 0; rsload = 0; rsload_t = 0; rsshr = 0; rsshr_t = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        mdld = 1; mrld = 1; rsload = 1; rsshr = 1;
        mdld_t = 1; mrld_t = 1; rsload_t = 1; rsshr_t = 1;
        multiplicand = 4'hF; multiplier = 4'hF; multiplicand_t = 1; multiplier_t = 1;
        tick();
        rst = 0; idle();
        multiplicand_t = 0; multiplier_t = 0;
        n_cmp++; if (product !== 8'h00) begin
            n_fail++; $display("FAIL reset_product: got %0h want 0", product);
        end
        n_cmp++; if (product_t !== 1'b0) begin
            n_fail++; $display("FAIL reset_product_t: got %0b want 0", product_t);
        end
        n_cmp++; if (multiplierReg !== 4'h0) begin
            n_fail++; $display("FAIL reset_mreg: got %0h want 0", multiplierReg);
        end
        n_cmp++; if (multiplierReg_t !== 1'b0) begin
            n_fail++; $display("FAIL reset_mreg_t: got %0b want 0", multiplierReg_t);
        end
        n_cmp++; if (ctrl_conflict !== 1'b0) begin
            n_fail++; $display("FAIL reset_conflict: got %0b want 0", ctrl_conflict);
        end
    endtask

    // Load + clear, then the initial shift.
    task automatic start_seq(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic a_t, input logic b_t);
        idle();
        multiplicand = a; multiplier = b; multiplicand_t = a_t; multiplier_t = b_t;
        mdld = 1; mrld = 1; rsclear = 1;
        tick();
        idle();
        n_cmp++; if (multiplierReg !== b || multiplierReg_t !== b_t) begin
            n_fail++; $display("FAIL load_mreg: got %0h/%0b want %0h/%0b",
                               multiplierReg, multiplierReg_t, b, b_t);
        end
        rsshr = 1; tick(); idle();
    endtask

    task automatic test_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic a_t, input logic b_t);
        int exp_p;
        bit exp_t;
        start_seq(a, b, a_t, b_t);
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                rsload = 1; tick(); idle();
            end
            rsshr = 1; tick(); idle();
        end
        exp_p = int'(a) * int'(b);
        exp_t = a_t && (b != 0);
        n_cmp++; if (int'(product) != exp_p) begin
            n_fail++; $display("FAIL mult_product %0d*%0d: got %0d want %0d", a, b, product, exp_p);
        end
        n_cmp++; if (product_t !== exp_t) begin
            n_fail++; $display("FAIL mult_product_t %0d*%0d: got %0b want %0b", a, b, product_t, exp_t);
        end
        n_cmp++; if (multiplierReg_t !== b_t) begin
            n_fail++; $display("FAIL mult_mreg_t: got %0b want %0b", multiplierReg_t, b_t);
        end
        n_cmp++; if (ctrl_conflict !== 1'b0) begin
            n_fail++; $display("FAIL mult_conflict: got %0b want 0", ctrl_conflict);
        end
        multiplicand_t = 0; multiplier_t = 0;
    endtask

    task automatic test_shr_taint();
        start_seq(4'd5, 4'd3, 1'b0, 1'b0);
        rsload = 1; tick(); idle();
        rsshr = 1; tick(); idle();
        rsshr_t = 1; tick(); idle();
        n_cmp++; if (product !== 8'h28 || product_t !== 1'b1) begin
            n_fail++; $display("FAIL shr_taint: got %0h/%0b want 28/1", product, product_t);
        end
        rsclear = 1; tick(); idle();
        n_cmp++; if (product !== 8'h00 || product_t !== 1'b0) begin
            n_fail++; $display("FAIL clear_untaint: got %0h/%0b want 0/0", product, product_t);
        end
    endtask

    task automatic test_conflict();
        start_seq(4'd5, 4'd3, 1'b0, 1'b0);
        rsload = 1; rsshr = 1; tick(); idle();
        n_cmp++; if (product !== 8'h50) begin
            n_fail++; $display("FAIL conflict_add_only: got %0h want 50", product);
        end
        n_cmp++; if (ctrl_conflict !== 1'b1) begin
            n_fail++; $display("FAIL conflict_set: got %0b want 1", ctrl_conflict);
        end
        rsclear = 1; tick(); idle();
        tick(); tick();
        n_cmp++; if (ctrl_conflict !== 1'b1) begin
            n_fail++; $display("FAIL conflict_sticky: got %0b want 1", ctrl_conflict);
        end
        rst = 1; tick(); rst = 0;
        n_cmp++; if (ctrl_conflict !== 1'b0) begin
            n_fail++; $display("FAIL conflict_rst: got %0b want 0", ctrl_conflict);
        end
    endtask

    task automatic test_reset_mid();
        start_seq(4'd15, 4'd15, 1'b1, 1'b1);
        rsload = 1; tick(); idle();
        rsshr = 1; tick(); idle();
        rsload = 1; tick(); idle();
        rsshr = 1; tick(); idle();
        rst = 1; tick(); rst = 0;
        multiplicand_t = 0; multiplier_t = 0;
        tick();
        n_cmp++; if (product !== 8'h00 || product_t !== 1'b0) begin
            n_fail++; $display("FAIL midrst_product: got %0h/%0b want 0/0", product, product_t);
        end
        n_cmp++; if (multiplierReg !== 4'h0 || multiplierReg_t !== 1'b0) begin
            n_fail++; $display("FAIL midrst_mreg: got %0h/%0b want 0/0",
                               multiplierReg, multiplierReg_t);
        end
        n_cmp++; if (ctrl_conflict !== 1'b0) begin
            n_fail++; $display("FAIL midrst_conflict: got %0b want 0", ctrl_conflict);
        end
    endtask

    task automatic test_random();
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 400; c++) begin
            rst            = ($urandom_range(0, 39) == 0);
            multiplicand   = W'($urandom_range(0, 15));
            multiplier     = W'($urandom_range(0, 15));
            multiplicand_t = ($urandom_range(0, 3) == 0);
            multiplier_t   = ($urandom_range(0, 3) == 0);
            mdld           = ($urandom_range(0, 3) == 0);
            mrld           = ($urandom_range(0, 3) == 0);
            rsclear        = ($urandom_range(0, 7) == 0);
            rsload         = ($urandom_range(0, 2) == 0);
            rsshr          = ($urandom_range(0, 1) == 0);
            mdld_t         = ($urandom_range(0, 9) == 0);
            mrld_t         = ($urandom_range(0, 9) == 0);
            rsclear_t      = ($urandom_range(0, 15) == 0);
            rsload_t       = ($urandom_range(0, 15) == 0);
            rsshr_t        = ($urandom_range(0, 15) == 0);
            tick();
            n_cmp++; if (int'(product) != (m_res % 256) || product_t !== m_res_t) begin
                n_fail++; $display("FAIL rand_product c%0d: got %0h/%0b want %0h/%0b",
                                   c, product, product_t, m_res % 256, m_res_t);
            end
            n_cmp++; if (int'(multiplierReg) != m_mr || multiplierReg_t !== m_mr_t) begin
                n_fail++; $display("FAIL rand_mreg c%0d: got %0h/%0b want %0h/%0b",
                                   c, multiplierReg, multiplierReg_t, m_mr, m_mr_t);
            end
            n_cmp++; if (ctrl_conflict !== m_conf) begin
                n_fail++; $display("FAIL rand_conflict c%0d: got %0b want %0b",
                                   c, ctrl_conflict, m_conf);
            end
        end
        rst = 0; idle();
        multiplicand_t = 0; multiplier_t = 0;
    endtask

    initial begin
        #2;
        test_reset();
        test_mult(4'd5, 4'd3, 1'b0, 1'b0);
        test_mult(4'd15, 4'd15, 1'b0, 1'b0);
        test_mult(4'd5, 4'd3, 1'b0, 1'b1);
        test_mult(4'd5, 4'd3, 1'b1, 1'b0);
        test_mult(4'd9, 4'd0, 1'b1, 1'b0);
        test_shr_taint();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
